// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch block: data widths, the PC
// increment, the fetch FSM state encoding and a word-alignment helper.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Branch targets are byte addresses; instructions live on word boundaries.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_wait_cnt.sv
// Clear/enable wait counter with a terminal-count flag at TERM-1.
// Used to time the instruction-memory read latency; written generically so
// the data-memory path can reuse it.
module fetch_wait_cnt #(
  parameter int TERM = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TERM < 2) ? 1 : $clog2(TERM + 1);

  logic [CW-1:0] cnt;

  // Clear wins over enable so a restart always begins a full wait period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(TERM - 1));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: addresses instruction memory with the PC,
// waits RD_WAIT cycles for the read, then offers the captured word to decode
// over a valid/ready handshake. Branch redirects override everything; fetch
// halts once the PC leaves [0, MEM_SIZE).
// Optional build macro: FETCH_TRACE_EN enables simulation trace messages.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int RD_WAIT  = 2,
  parameter int MEM_SIZE = 40,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               halted
);

  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_VALID = ST_VALID;
  localparam logic [1:0] S_HALT  = ST_HALT;

  localparam logic [ADDR_W-1:0] MEM_LIMIT  = ADDR_W'(MEM_SIZE);
  localparam logic [ADDR_W-1:0] PC_AT_RST  = ADDR_W'(RESET_PC);

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] seq_pc;
  logic              wait_clr;
  logic              wait_en;
  logic              wait_tc;
  logic              capture;
  logic              transfer;

  assign transfer = (state == S_VALID) && instr_ready;
  assign seq_pc   = pc + PC_STEP;
  assign wait_en  = (state == S_FETCH);

  fetch_wait_cnt #(
    .TERM (RD_WAIT)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wait_clr),
    .en    (wait_en),
    .tc    (wait_tc)
  );

  // Next-state/PC selection; a redirect pre-empts fetch, hold and halt alike,
  // and also discards any read that was still settling.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    wait_clr   = 1'b0;
    capture    = 1'b0;
    if (redirect_valid) begin
      next_pc    = word_align(redirect_target);
      wait_clr   = 1'b1;
      next_state = (redirect_target >= MEM_LIMIT) ? S_HALT : S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (wait_tc) begin
            capture    = 1'b1;
            next_state = S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            next_pc    = seq_pc;
            wait_clr   = 1'b1;
            next_state = (seq_pc >= MEM_LIMIT) ? S_HALT : S_FETCH;
          end
        end
        S_HALT: begin
          next_state = S_HALT;
        end
        default: begin
          next_state = S_HALT;
        end
      endcase
    end
  end

  // Control state and PC; the PC register doubles as the memory address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= PC_AT_RST;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  // Instruction holding register, loaded only when a read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out <= '0;
      instr_pc  <= '0;
    end else if (capture) begin
      instr_out <= imem_instr;
      instr_pc  <= pc;
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = (state == S_VALID);
  assign halted      = (state == S_HALT);

`ifdef FETCH_TRACE_EN
  // Simulation-only trace of deliveries, redirects and halt entry.
  always @(posedge clk) begin
    if (rst_n) begin
      if (transfer)
        $display("[fetch] t=%0t deliver pc=%08h instr=%08h", $time, instr_pc, instr_out);
      if (redirect_valid)
        $display("[fetch] t=%0t redirect pc %08h -> %08h", $time, pc, word_align(redirect_target));
      if ((next_state == S_HALT) && (state != S_HALT))
        $display("[fetch] t=%0t entering halt", $time);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with RD_WAIT=2, MEM_SIZE=20, RESET_PC=0.
// The instruction memory is a fixed function of the address so every
// expected instruction word can be written down by hand.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halted;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        rdy;
    logic        ev;
    logic        eh;
    logic [31:0] ea;
    logic [31:0] epc;
    logic [31:0] eo;
  } vec_t;

  vec_t vecs [16];

  fetch_ctrl #(
    .RD_WAIT  (2),
    .MEM_SIZE (20),
    .RESET_PC (0)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .halted          (halted)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Combinational instruction memory model.
  always_comb imem_instr = memw(imem_addr);

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic ev, input logic eh,
                             input logic [31:0] ea, input logic [31:0] epc,
                             input logic [31:0] eo);
    checkField({tag, ".valid"},  {31'd0, instr_valid}, {31'd0, ev});
    checkField({tag, ".halted"}, {31'd0, halted},      {31'd0, eh});
    checkField({tag, ".addr"},   imem_addr, ea);
    checkField({tag, ".pc"},     instr_pc,  epc);
    checkField({tag, ".instr"},  instr_out, eo);
  endtask

  task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rt);
    instr_ready     = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clk);
    #1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic doReset();
    rst_n           = 1'b0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
  endtask

  // Global watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Straight-line program with decode always ready; 3 cycles per word.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  32'd0,  32'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'd0,  32'd0,  memw(32'd0)};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 32'd4,  32'd0,  memw(32'd0)};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'd4,  32'd0,  memw(32'd0)};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'd4,  32'd4,  memw(32'd4)};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 32'd8,  32'd4,  memw(32'd4)};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 32'd8,  32'd4,  memw(32'd4)};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'd8,  32'd8,  memw(32'd8)};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 32'd12, 32'd8,  memw(32'd8)};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'd12, 32'd8,  memw(32'd8)};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'd12, 32'd12, memw(32'd12)};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'd16, 32'd12, memw(32'd12)};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'd16, 32'd12, memw(32'd12)};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 32'd16, 32'd16, memw(32'd16)};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 32'd20, 32'd16, memw(32'd16)};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 32'd20, 32'd16, memw(32'd16)};

    doReset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rdy, 1'b0, 32'd0);
      checkOutput($sformatf("run%0d", i + 1), vecs[i].ev, vecs[i].eh,
                  vecs[i].ea, vecs[i].epc, vecs[i].eo);
    end

    // Decode stalls for 5 cycles while pc=4 is valid; exactly one transfer.
    doReset();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("stall_e1", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("stall_e2", 1'b1, 1'b0, 32'd0, 32'd0, memw(32'd0));
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("stall_e3", 1'b0, 1'b0, 32'd4, 32'd0, memw(32'd0));
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("stall_e5", 1'b1, 1'b0, 32'd4, 32'd4, memw(32'd4));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput($sformatf("stall_hold%0d", i), 1'b1, 1'b0, 32'd4, 32'd4, memw(32'd4));
    end
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("stall_accept", 1'b0, 1'b0, 32'd8, 32'd4, memw(32'd4));

    // Redirect to 16 while fetching pc=8: the pc=8 word is dropped.
    applyStimulus(1'b0, 1'b1, 32'd16);
    checkOutput("redir_f_e0", 1'b0, 1'b0, 32'd16, 32'd4, memw(32'd4));
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("redir_f_e1", 1'b0, 1'b0, 32'd16, 32'd4, memw(32'd4));
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("redir_f_e2", 1'b1, 1'b0, 32'd16, 32'd16, memw(32'd16));
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("redir_f_halt", 1'b0, 1'b1, 32'd20, 32'd16, memw(32'd16));

    // From HALT: out-of-range redirect stays halted, in-range one restarts.
    applyStimulus(1'b0, 1'b1, 32'd40);
    checkOutput("halt_r40", 1'b0, 1'b1, 32'd40, 32'd16, memw(32'd16));
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("halt_r40_hold", 1'b0, 1'b1, 32'd40, 32'd16, memw(32'd16));
    applyStimulus(1'b0, 1'b1, 32'd0);
    checkOutput("halt_r0", 1'b0, 1'b0, 32'd0, 32'd16, memw(32'd16));
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("halt_r0_valid", 1'b1, 1'b0, 32'd0, 32'd0, memw(32'd0));

    // Redirect to 0x13 together with the accept of pc=12.
    applyStimulus(1'b0, 1'b1, 32'd12);
    checkOutput("coinc_r12", 1'b0, 1'b0, 32'd12, 32'd0, memw(32'd0));
    applyStimulus(1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("coinc_v12", 1'b1, 1'b0, 32'd12, 32'd12, memw(32'd12));
    applyStimulus(1'b1, 1'b1, 32'h13);
    checkOutput("coinc_accept", 1'b0, 1'b0, 32'd16, 32'd12, memw(32'd12));
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("coinc_e1", 1'b0, 1'b0, 32'd16, 32'd12, memw(32'd12));
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("coinc_v16", 1'b1, 1'b0, 32'd16, 32'd16, memw(32'd16));

    // Reset asserted mid-fetch (pc=4, cnt=1) takes effect without a clock.
    applyStimulus(1'b0, 1'b1, 32'd4);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("midrst_pre", 1'b0, 1'b0, 32'd4, 32'd16, memw(32'd16));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_async", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("midrst_e1", 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("midrst_e2", 1'b1, 1'b0, 32'd0, 32'd0, memw(32'd0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
